// File: rtl/reset_sequencer.sv
// reset_sequencer: staged multi-channel reset release after qualified PLL lock; optional watchdog via RESET_SEQ_WDT_EN
module reset_sequencer #(
   parameter int NUM_OUT     = 2,
   parameter int HOLD_CYCLES = 4194303,
   parameter int STAGE_GAP   = 16,
   parameter int LOCK_FILTER = 256,
   parameter int WDT_CYCLES  = 1048576
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               sw_reset_req,
   input  logic               wdt_kick,
   output logic [NUM_OUT-1:0] reset_out,
   output logic               ready,
   output logic [1:0]         state,
   output logic [7:0]         lock_loss_count,
   output logic               wdt_expired
);
   localparam logic [1:0] HOLD  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] STAGE = 2'd2;
   localparam logic [1:0] RUN   = 2'd3;
   localparam int CW = $clog2((HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP) + 1);
   localparam int LW = $clog2(LOCK_FILTER + 1);
   localparam logic [NUM_OUT-1:0] LAST = NUM_OUT'(1) << (NUM_OUT - 1);
   logic [1:0]    rst_ff;
   logic [1:0]    lock_ff;
   logic          rst_sync;
   logic          lock_sync;
   logic          lock_ok;
   logic [LW-1:0] filt;
   logic [CW-1:0] cnt;
   logic          active;
   logic          lock_abort;
   logic          abort;
   logic          last;
   logic          wdt_fire;
   assign rst_sync   = rst_ff[1];
   assign lock_sync  = lock_ff[1];
   assign lock_ok    = filt == LW'(LOCK_FILTER);
   assign active     = state != HOLD;
   assign lock_abort = active && !lock_sync;
   assign abort      = lock_abort || (active && sw_reset_req) || wdt_fire;
   // the channel being released is the last one once only the top bit is still set
   assign last       = reset_out == LAST;
   // reset synchroniser: asserts immediately, releases two edges later
   always_ff @(posedge clock or negedge reset)
      if (!reset) rst_ff <= '0;
      else rst_ff <= {rst_ff[0], 1'b1};
   // two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clock or negedge reset)
      if (!reset) lock_ff <= '0;
      else lock_ff <= {lock_ff[0], pll_lock};
   // lock qualification: count consecutive high cycles, saturating at the filter length
   always_ff @(posedge clock or negedge reset)
      if (!reset) filt <= '0;
      else if (!lock_sync || abort) filt <= '0;
      else if (!lock_ok) filt <= filt + 1'b1;
   // stretch, then release channels one gap apart by shifting zeros in from bit 0
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state     <= HOLD;
         reset_out <= '1;
         ready     <= 1'b0;
         cnt       <= '0;
      end else if (abort) begin
         state     <= HOLD;
         reset_out <= '1;
         ready     <= 1'b0;
         cnt       <= '0;
      end else if (state == HOLD) begin
         if (rst_sync && lock_ok && !sw_reset_req) begin
            state <= COUNT;
            cnt   <= CW'(HOLD_CYCLES - 1);
         end
      end else if (state != RUN) begin
         if (cnt != '0) cnt <= cnt - 1'b1;
         else begin
            reset_out <= reset_out << 1;
            cnt       <= CW'(STAGE_GAP - 1);
            state     <= last ? RUN : STAGE;
            ready     <= last;
         end
      end
   // saturating count of aborts caused by losing lock
   always_ff @(posedge clock or negedge reset)
      if (!reset) lock_loss_count <= '0;
      else if (lock_abort && lock_loss_count != 8'hff) lock_loss_count <= lock_loss_count + 1'b1;
`ifdef RESET_SEQ_WDT_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);
   logic [WW-1:0] wdt;
   assign wdt_fire = state == RUN && wdt == '0 && !wdt_kick;
   // watchdog: held at full count outside RUN so it starts fresh on RUN entry; kicks reload it
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wdt         <= '0;
         wdt_expired <= 1'b0;
      end else begin
         wdt_expired <= wdt_fire;
         wdt         <= (state != RUN || wdt_kick) ? WW'(WDT_CYCLES - 1) : wdt - 1'b1;
      end
`else
   logic unused_wdt;
   assign unused_wdt  = wdt_kick | (WDT_CYCLES < 1);
   assign wdt_fire    = 1'b0;
   assign wdt_expired = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus with an elapsed-time reference model for reset_sequencer
module tb_reset_sequencer;
   localparam int NUM_OUT     = 3;
   localparam int HOLD_CYCLES = 16;
   localparam int STAGE_GAP   = 4;
   localparam int LOCK_FILTER = 8;
   localparam int WDT_CYCLES  = 32;
   localparam int T_RUN       = HOLD_CYCLES + (NUM_OUT - 1) * STAGE_GAP;
`ifdef RESET_SEQ_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif
   logic               clock = 1'b0;
   logic               reset;
   logic               pll_lock = 1'b0;
   logic               sw_reset_req = 1'b0;
   logic               wdt_kick = 1'b0;
   logic [NUM_OUT-1:0] reset_out;
   logic               ready;
   logic [1:0]         state;
   logic [7:0]         lock_loss_count;
   logic               wdt_expired;
   int                 n_cmp = 0;
   int                 n_bad = 0;
   logic               started = 1'b0;

   reset_sequencer #(
      .NUM_OUT(NUM_OUT), .HOLD_CYCLES(HOLD_CYCLES), .STAGE_GAP(STAGE_GAP),
      .LOCK_FILTER(LOCK_FILTER), .WDT_CYCLES(WDT_CYCLES)
   ) dut (
      .clock(clock), .reset(reset), .pll_lock(pll_lock), .sw_reset_req(sw_reset_req),
      .wdt_kick(wdt_kick), .reset_out(reset_out), .ready(ready), .state(state),
      .lock_loss_count(lock_loss_count), .wdt_expired(wdt_expired)
   );

   always #5 clock = ~clock;

   // Reference model: sequencing is tracked as elapsed edges e_m since COUNT entry;
   // every output is a threshold test on that elapsed time.
   logic [1:0]         rs_m;
   logic [1:0]         ls_m;
   int                 run_m;
   int                 e_m;
   int                 idle_m;
   int                 llc_m;
   logic               seq_m;
   logic               wexp_m;
   logic               in_run;
   logic               ab_lock;
   logic               wfire;
   logic               ab;
   logic               go;
   logic [1:0]         st_x;
   logic [NUM_OUT-1:0] ro_x;
   assign in_run  = seq_m && e_m >= T_RUN;
   assign ab_lock = seq_m && !ls_m[1];
   assign wfire   = WDT_ON && in_run && idle_m == WDT_CYCLES - 1 && !wdt_kick;
   assign ab      = ab_lock || (seq_m && sw_reset_req) || wfire;
   assign go      = !seq_m && rs_m[1] && run_m == LOCK_FILTER && !sw_reset_req;

   always @(posedge clock or negedge reset)
      if (!reset) begin
         rs_m   <= '0;
         ls_m   <= '0;
         run_m  <= 0;
         seq_m  <= 1'b0;
         e_m    <= 0;
         idle_m <= 0;
         llc_m  <= 0;
         wexp_m <= 1'b0;
      end else begin
         rs_m   <= {rs_m[0], 1'b1};
         ls_m   <= {ls_m[0], pll_lock};
         run_m  <= (!ls_m[1] || ab) ? 0 : (run_m < LOCK_FILTER ? run_m + 1 : run_m);
         seq_m  <= ab ? 1'b0 : (seq_m || go);
         e_m    <= (ab || !seq_m) ? 0 : (e_m < T_RUN ? e_m + 1 : e_m);
         idle_m <= (!in_run || wdt_kick) ? 0 : idle_m + 1;
         llc_m  <= (ab_lock && llc_m < 255) ? llc_m + 1 : llc_m;
         wexp_m <= wfire;
      end

   always_comb begin
      st_x = !seq_m ? 2'd0 : e_m < HOLD_CYCLES ? 2'd1 : e_m < T_RUN ? 2'd2 : 2'd3;
      ro_x = '0;
      for (int k = 0; k < NUM_OUT; k++) ro_x[k] = !seq_m || e_m < HOLD_CYCLES + k * STAGE_GAP;
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clock)
      if (started) begin
         n_cmp++;
         if ({state, reset_out, ready, lock_loss_count, wdt_expired} !== {st_x, ro_x, in_run, 8'(llc_m), wexp_m}) begin
            n_bad++;
            $display("FAIL model t=%0t got st=%0d ro=%b rdy=%b llc=%0d wdt=%b required st=%0d ro=%b rdy=%b llc=%0d wdt=%b",
                     $time, state, reset_out, ready, lock_loss_count, wdt_expired, st_x, ro_x, in_run, llc_m, wexp_m);
         end
      end

   function automatic logic [14:0] outs();
      return {state, reset_out, ready, lock_loss_count, wdt_expired};
   endfunction

   function automatic bit probe(input int sel);
      case (sel)
         0: return state == 2'd0;
         1: return state == 2'd1;
         2: return state == 2'd2;
         3: return ready;
         4: return !reset_out[0];
         5: return !reset_out[1];
         6: return !reset_out[2] && ready;
         7: return wdt_expired;
         default: return reset_out == 3'b111 && !ready;
      endcase
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic edges_until(input int sel, input int lim, output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!probe(sel) && n < lim);
      n_cmp++;
      if (!probe(sel)) begin
         n_bad++;
         $display("FAIL wait sel=%0d: condition not seen after %0d edges", sel, n);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 started = 1'b1;
      check("reset_values", outs(), {2'd0, 3'b111, 1'b0, 8'd0, 1'b0});
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      check("hold_without_lock", outs(), {2'd0, 3'b111, 1'b0, 8'd0, 1'b0});
      // lock rises: 2 sync edges, 8 filter edges, COUNT on the next
      pll_lock = 1'b1;
      edges_until(1, 40, n);
      check("lock_to_count", n, 11);
      edges_until(4, 40, n);
      check("count_to_rst0", n, 16);
      edges_until(5, 20, n);
      check("rst0_to_rst1", n, 4);
      edges_until(6, 20, n);
      check("rst1_to_rst2_ready", n, 4);
      // one-cycle lock drop in RUN
      @(negedge clock) pll_lock = 1'b0;
      @(negedge clock) pll_lock = 1'b1;
      edges_until(8, 10, n);
      check("lockdrop_to_abort", n, 2);
      check("llc_after_drop", lock_loss_count, 1);
      edges_until(3, 80, n);
      check("rerun_to_ready", n, 33);
      // software request alone in RUN
      @(negedge clock) sw_reset_req = 1'b1;
      @(negedge clock) sw_reset_req = 1'b0;
      check("sw_abort_state", state, 0);
      check("sw_abort_llc", lock_loss_count, 1);
      // lock loss and software request seen together in STAGE
      edges_until(2, 60, n);
      @(negedge clock) pll_lock = 1'b0;
      @(negedge clock);
      @(negedge clock) sw_reset_req = 1'b1;
      @(negedge clock) begin
         sw_reset_req = 1'b0;
         pll_lock = 1'b1;
      end
      check("combined_abort_state", state, 0);
      check("combined_abort_llc", lock_loss_count, 2);
      // lock glitching shorter than the filter in HOLD
      for (int g = 0; g < 6; g++) begin
         pll_lock = 1'b1;
         repeat (5) @(negedge clock);
         pll_lock = 1'b0;
         @(negedge clock);
      end
      check("glitch_hold", outs(), {2'd0, 3'b111, 1'b0, 8'd2, 1'b0});
      // software request held keeps HOLD even with good lock
      sw_reset_req = 1'b1;
      pll_lock = 1'b1;
      repeat (20) @(negedge clock);
      check("sw_held_state", state, 0);
      sw_reset_req = 1'b0;
      edges_until(1, 5, n);
      check("sw_release_to_count", n, 1);
      // 300 further lock-loss aborts saturate the counter
      for (int i = 0; i < 300; i++) begin
         edges_until(1, 40, n);
         @(negedge clock) pll_lock = 1'b0;
         @(negedge clock) pll_lock = 1'b1;
         edges_until(0, 10, n);
         if (i == 251) check("llc_254", lock_loss_count, 254);
      end
      check("llc_saturated", lock_loss_count, 255);
      // asynchronous reset in the middle of COUNT
      edges_until(1, 40, n);
      @(negedge clock);
      #2 reset = 1'b0;
      #1 check("async_reset_values", outs(), {2'd0, 3'b111, 1'b0, 8'd0, 1'b0});
      @(negedge clock) reset = 1'b1;
      edges_until(3, 80, n);
`ifdef RESET_SEQ_WDT_EN
      edges_until(7, 40, n);
      check("wdt_timeout_edges", n, 32);
      check("wdt_abort_outputs", {reset_out, ready}, {3'b111, 1'b0});
      edges_until(3, 80, n);
      for (int j = 0; j < 5; j++) begin
         repeat (19) @(negedge clock);
         wdt_kick = 1'b1;
         @(negedge clock) wdt_kick = 1'b0;
      end
      check("kicked_still_run", {state, ready}, {2'd3, 1'b1});
`else
      @(negedge clock) wdt_kick = 1'b1;
      @(negedge clock) wdt_kick = 1'b0;
      repeat (40) @(negedge clock);
      check("no_watchdog_run", {state, ready, wdt_expired}, {2'd3, 1'b1, 1'b0});
`endif
      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
